// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM states, error codes and
// frame geometry.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    ERROR     = 3'd6
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_START_TO = 2'd1,
    ERR_XFER_TO  = 2'd2,
    ERR_NO_ACK   = 2'd3
  } ps2_err_e;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge pulse.
// Idle level of the bus is high, so the flops reset to 1.
module ps2_line_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pin_in,
  output logic level_out,
  output logic fall_out
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[1:0], pin_in};
    end
  end

  assign level_out = sync_q[1];
  assign fall_out  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// frame, ACK check and timeouts. Lines are driven open-drain via output enables.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 12000,
  parameter int unsigned START_TIMEOUT_CYCLES = 1500000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 200000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe_out,
  output logic       ps2_data_oe_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out,
  output logic [1:0] err_code_out
);

  localparam int unsigned INH_W   = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned START_W = $clog2(START_TIMEOUT_CYCLES + 1);
  localparam int unsigned XFER_W  = $clog2(XFER_TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0]   INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0]   INH_START  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [XFER_W-1:0]  XFER_LAST  = XFER_W'(XFER_TIMEOUT_CYCLES - 1);

  // Edge counts within the frame: data bits occupy edges 1..8.
  localparam logic [3:0] PARITY_IDX = 4'(PS2_FRAME_BITS - 3);
  localparam logic [3:0] STOP_IDX   = 4'(PS2_FRAME_BITS - 2);

  ps2_state_e         state;
  logic [7:0]         data_q;
  logic               parity_q;
  logic [3:0]         bit_idx;
  logic [INH_W-1:0]   inh_cnt;
  logic [START_W-1:0] start_cnt;
  logic [XFER_W-1:0]  xfer_cnt;

  logic     clk_lvl, clk_fall;
  logic     data_lvl, data_fall;
  logic     fail_now;
  ps2_err_e fail_code;

  ps2_line_sync u_clk_sync (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pin_in    (ps2_clk_in),
    .level_out (clk_lvl),
    .fall_out  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pin_in    (ps2_data_in),
    .level_out (data_lvl),
    .fall_out  (data_fall)
  );

  assign ready_out = (state == IDLE);
  assign busy_out  = (state != IDLE);

  // All abort conditions resolved in one place so the sequential block only
  // needs a single priority branch into ERROR.
  always_comb begin
    fail_now  = 1'b0;
    fail_code = ERR_NONE;
    case (state)
      REQ: begin
        if (!clk_fall && start_cnt == START_LAST) begin
          fail_now  = 1'b1;
          fail_code = ERR_START_TO;
        end
      end
      SHIFT, ACK, WAIT_IDLE: begin
        if (xfer_cnt == XFER_LAST && !done_out) begin
          fail_now  = 1'b1;
          fail_code = ERR_XFER_TO;
        end else if (state == ACK && clk_fall && data_lvl) begin
          fail_now  = 1'b1;
          fail_code = ERR_NO_ACK;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      data_q          <= '0;
      parity_q        <= 1'b0;
      bit_idx         <= '0;
      inh_cnt         <= '0;
      start_cnt       <= '0;
      xfer_cnt        <= '0;
      ps2_clk_oe_out  <= 1'b0;
      ps2_data_oe_out <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
      err_code_out    <= ERR_NONE;
    end else begin
      done_out  <= 1'b0;
      error_out <= 1'b0;
      if (fail_now) begin
        state           <= ERROR;
        ps2_clk_oe_out  <= 1'b0;
        ps2_data_oe_out <= 1'b0;
        error_out       <= 1'b1;
        err_code_out    <= fail_code;
      end else begin
        case (state)
          IDLE: begin
            if (valid_in) begin
              data_q         <= data_in;
              parity_q       <= odd_parity(data_in);
              inh_cnt        <= '0;
              ps2_clk_oe_out <= 1'b1;
              state          <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt != INH_LAST) inh_cnt <= inh_cnt + 1'b1;
            // Start bit goes low during the last clock-low cycle.
            if (inh_cnt == INH_START) ps2_data_oe_out <= 1'b1;
            if (inh_cnt == INH_LAST) begin
              ps2_clk_oe_out <= 1'b0;
              start_cnt      <= '0;
              state          <= REQ;
            end
          end
          REQ: begin
            if (clk_fall) begin
              ps2_data_oe_out <= ~data_q[0];
              bit_idx         <= 4'd1;
              xfer_cnt        <= '0;
              state           <= SHIFT;
            end else if (start_cnt != START_LAST) begin
              start_cnt <= start_cnt + 1'b1;
            end
          end
          SHIFT: begin
            if (xfer_cnt != XFER_LAST) xfer_cnt <= xfer_cnt + 1'b1;
            if (clk_fall) begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx < PARITY_IDX) begin
                ps2_data_oe_out <= ~data_q[bit_idx[2:0]];
              end else if (bit_idx == PARITY_IDX) begin
                ps2_data_oe_out <= ~parity_q;
              end else begin
                ps2_data_oe_out <= 1'b0;
                state           <= ACK;
              end
            end
          end
          ACK: begin
            if (xfer_cnt != XFER_LAST) xfer_cnt <= xfer_cnt + 1'b1;
            if (clk_fall) state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (xfer_cnt != XFER_LAST) xfer_cnt <= xfer_cnt + 1'b1;
            if (done_out) begin
              state <= IDLE;
            end else if (clk_lvl && data_lvl) begin
              done_out <= 1'b1;
            end
          end
          ERROR: begin
            state <= IDLE;
          end
          default: begin
            state           <= IDLE;
            ps2_clk_oe_out  <= 1'b0;
            ps2_data_oe_out <= 1'b0;
          end
        endcase
      end
    end
  end

  // Data-line falling edges carry no meaning for the transmitter.
  logic unused_data_fall;
  assign unused_data_fall = data_fall;

  // Stop index is implied by the else branch in SHIFT; kept for readability.
  logic unused_stop_idx;
  assign unused_stop_idx = ^STOP_IDX;

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx with a behavioural PS/2 device on the bus.
module tb_ps2_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe_out, ps2_data_oe_out;
  logic       busy_out, done_out, error_out;
  logic [1:0] err_code_out;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  // Wired-AND open-drain bus with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe_out  | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe_out | dev_data_low);

  ps2_tx #(
    .INHIBIT_CYCLES       (20),
    .START_TIMEOUT_CYCLES (500),
    .XFER_TIMEOUT_CYCLES  (4000)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .ps2_clk_in      (ps2_clk_in),
    .ps2_data_in     (ps2_data_in),
    .ps2_clk_oe_out  (ps2_clk_oe_out),
    .ps2_data_oe_out (ps2_data_oe_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .error_out       (error_out),
    .err_code_out    (err_code_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       is_err;
    logic [1:0] code;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc = 0;
  int unsigned release_cyc = 0;
  int unsigned pulse_cyc = 0;
  int unsigned inh_run = 0;
  int          pulse_cnt = 0;
  bit          chk_ready_next = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: inhibit length, pulse scoreboard, ready-after-pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      inh_run = 0;
    end else if (ps2_clk_oe_out) begin
      inh_run++;
    end else if (inh_run != 0) begin
      check("inhibit_len", inh_run, 20);
      inh_run = 0;
      release_cyc = cyc;
    end
    if (chk_ready_next) begin
      check("ready_after_pulse", {31'd0, ready_out}, 1);
      chk_ready_next = 1'b0;
    end
    if (done_out || error_out) begin
      exp_t e;
      pulse_cyc = cyc;
      pulse_cnt++;
      chk_ready_next = 1'b1;
      check("ready_in_pulse", {31'd0, ready_out}, 0);
      check("pulse_both", {31'd0, done_out & error_out}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_err", {31'd0, error_out}, {31'd0, e.is_err});
        if (e.is_err) check("err_code", {30'd0, err_code_out}, {30'd0, e.code});
      end
    end
  end

  // Device: samples start bit, clocks n_edges bits (sampling at rising edges),
  // then optionally the ACK clock with data driven low if ack is set.
  task automatic dev_run(input int n_edges, input bit ack, output logic [10:0] frame);
    frame = '0;
    if (n_edges == 0) return;
    repeat (30) @(negedge clk);
    frame[0] = ps2_data_in;
    for (int i = 1; i <= 10 && i <= n_edges; i++) begin
      dev_clk_low = 1'b1;
      repeat (50) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (50) @(negedge clk);
      frame[i] = ps2_data_in;
    end
    if (n_edges >= 11) begin
      dev_data_low = ack;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (50) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input int n_edges, input bit ack,
                      input bit is_err, input logic [1:0] code,
                      input bit poke_busy, input bit expect_pulse,
                      output logic [10:0] frame);
    int t;
    int pc0;
    t = 0;
    while (!ready_out && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", {31'd0, ready_out}, 1);
    if (expect_pulse) exp_q.push_back('{data: d, is_err: is_err, code: code});
    pc0 = pulse_cnt;
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 8'($urandom);
    check("busy_after_accept", {31'd0, busy_out}, 1);
    if (poke_busy) begin
      data_in  = 8'h55;
      valid_in = 1'b1;
      repeat (5) @(negedge clk);
      valid_in = 1'b0;
    end
    t = 0;
    while (!(ps2_clk_oe_out == 1'b0 && ps2_data_oe_out == 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("start_bit_driven", {30'd0, ps2_clk_oe_out, ps2_data_oe_out}, 1);
    dev_run(n_edges, ack, frame);
    if (n_edges >= 10) check("frame", {21'd0, frame}, {21'd0, exp_frame(d)});
    if (!expect_pulse) return;
    t = 0;
    while (pulse_cnt == pc0 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("pulse_seen", {31'd0, pulse_cnt != pc0}, 1);
    if (is_err && code == 2'd1) check("start_to_latency", pulse_cyc - release_cyc, 500);
    if (is_err && code == 2'd2)
      check("xfer_to_window", {31'd0, (pulse_cyc - release_cyc) inside {[4000:4100]}}, 1);
    repeat (3) @(negedge clk);
    check("lines_released", {30'd0, ps2_clk_oe_out, ps2_data_oe_out}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] frame;
    int pc_rst;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready_out}, 1);
    check("rst_busy", {31'd0, busy_out}, 0);
    check("rst_oe", {30'd0, ps2_clk_oe_out, ps2_data_oe_out}, 0);
    check("rst_pulses", {30'd0, done_out, error_out}, 0);
    check("rst_err_code", {30'd0, err_code_out}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hED, 11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, frame);
    check("frame_ed_const", {21'd0, frame}, 32'h7DA);
    send(8'h01, 11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, frame);
    check("parity_01", {31'd0, frame[9]}, 0);
    send(8'hFF, 11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, frame);
    check("parity_ff", {31'd0, frame[9]}, 1);

    send(8'h3C, 0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, frame);
    send(8'hA7, 11, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, frame);
    repeat (20) @(negedge clk);
    check("err_code_hold", {30'd0, err_code_out}, 3);
    send(8'h12, 4, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, frame);

    // Reset in the middle of data bit 5.
    pc_rst = pulse_cnt;
    send(8'hC3, 6, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, frame);
    check("mid_busy", {31'd0, busy_out}, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_oe", {30'd0, ps2_clk_oe_out, ps2_data_oe_out}, 0);
    check("async_rst_ready", {31'd0, ready_out}, 1);
    repeat (5) @(negedge clk);
    check("rst_no_pulse", pulse_cnt - pc_rst, 0);
    check("rst_err_code_clear", {30'd0, err_code_out}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hF4, 11, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, frame);
    repeat (60) @(negedge clk);
    check("no_latch_while_busy", {31'd0, busy_out}, 0);
    check("post_rst_pulses", pulse_cnt - pc_rst, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
